// File: rtl/myo_spi_responder.sv
// Mode-0 SPI slave emulating one myocontrol muscle-unit board: receives a fixed-length
// command frame on mosi and returns a status frame captured from tx_data on miso.
module myo_spi_responder #(
  parameter int WORD_BITS   = 16,
  parameter int N_WORDS     = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sck,
  input  logic                           ss_n,
  input  logic                           mosi,
  output logic                           miso,
  output logic                           miso_oe,
  input  logic [WORD_BITS*N_WORDS-1:0]   tx_data,
  output logic [WORD_BITS*N_WORDS-1:0]   rx_data,
  output logic                           rx_valid,
  output logic                           frame_err,
  output logic [15:0]                    frame_count,
  output logic [1:0]                     state_dbg
);

  localparam int TOTAL  = WORD_BITS * N_WORDS;
  localparam int CW     = $clog2(TOTAL + 2);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_h, ss_h;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;

  logic [TOTAL-1:0]       tx_shift, rx_shift;
  logic [CW-1:0]          bit_cnt;
  logic [SW-1:0]          settle_cnt;
  logic                   settle_done;
  logic                   done_good, done_bad;

  logic                   start, do_rise, do_fall, end_frame;

  // All three inputs see the same number of flops so mosi stays aligned with sck.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_h     <= 1'b0;
      ss_h      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_h     <= sck_s;
      ss_h      <= ss_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_h;
  assign sck_fall = ~sck_s & sck_h;
  assign ss_rise  = ss_s & ~ss_h;
  assign ss_fall  = ~ss_s & ss_h;

  // The synchronizers reset to ss_n=1, so a select held low through reset would look
  // like a fresh fall; wait until the chain has flushed before trusting ss_n=1.
  assign settle_done = (settle_cnt == SW'(SETTLE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= WAIT_IDLE;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!settle_done) settle_cnt <= settle_cnt + SW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    do_rise   = 1'b0;
    do_fall   = 1'b0;
    end_frame = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (settle_done && ss_s && ss_h) state_nxt = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          start     = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        // Deselect wins over an sck edge seen in the same cycle.
        if (ss_rise) begin
          end_frame = 1'b1;
          state_nxt = IDLE;
        end else if (sck_rise) begin
          do_rise = 1'b1;
        end else if (sck_fall) begin
          do_fall = 1'b1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      done_good   <= 1'b0;
      done_bad    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      done_good <= 1'b0;
      done_bad  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (start) begin
        tx_shift <= tx_data;
        miso     <= tx_data[TOTAL-1];
        miso_oe  <= 1'b1;
        bit_cnt  <= '0;
      end

      // bit_cnt saturates one past TOTAL so any overrun stays distinguishable.
      if (do_rise) begin
        rx_shift <= {rx_shift[TOTAL-2:0], mosi_s};
        if (bit_cnt != CW'(TOTAL + 1)) bit_cnt <= bit_cnt + CW'(1);
      end

      // Zero fill from the left shift drives miso low once all TOTAL bits are out.
      if (do_fall) begin
        tx_shift <= {tx_shift[TOTAL-2:0], 1'b0};
        miso     <= tx_shift[TOTAL-2];
      end

      if (end_frame) begin
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        done_good <= (bit_cnt == CW'(TOTAL));
        done_bad  <= (bit_cnt != CW'(TOTAL));
      end

      if (done_good) begin
        rx_data     <= rx_shift;
        rx_valid    <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end

      if (done_bad) frame_err <= 1'b1;
    end
  end

endmodule
